led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Parametrised LED / segment pattern sequencer for the board demo designs.
- A clock-enable prescaler, not a derived clock, advances a WIDTH-bit pattern register.
- Selectable modes: rotate left, rotate right, bounce, fill.
- Provides periodic reload, run/pause, synchronous restart, a polarity option and a switch OR-overlay; drives LED banks or segment lines directly.

Parameters:
- WIDTH, 16, pattern / LED width (>=2).
- TICK_DIV, 33554432, mclk cycles per step (>=2).
- RELOAD_STEPS, 16, ticks between automatic seed reloads; 0 disables reload.
- STEP_W, 8, width of step counter; RELOAD_STEPS <= 2^STEP_W.
- POLARITY, 0, 0 = walking-zero output (active marker is 0), 1 = walking-one.

Ports:
- mclk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  1 = prescaler counts; 0 = freeze.
- restart  in  1  synchronous single-cycle re-seed request.
- mode  in  2  00 rotl, 01 rotr, 10 bounce, 11 fill.
- sw  in  WIDTH  overlay; OR-ed into output.
- pat  out  WIDTH  (POLARITY ? r : ~r) | sw, combinational from registers.
- tick  out  1  registered one-cycle step strobe.
- step  out  STEP_W  steps since last reload.

Behaviour:
- Internal state:
  - r[WIDTH-1:0]: pattern register.
  - dir: bounce direction, 0 = toward MSB.
  - div_cnt: prescaler.
  - step: step counter.
  - mode_q: last applied mode.
- Seed = {0..0,1}: position 0 for every mode.
- Reset: r=seed, dir=0, div_cnt=0, step=0, tick=0, mode_q=00. With POLARITY=0 and sw=0, pat = all ones except bit0 (e.g. 16'hFFFE).
- Priority, highest first: rst > restart > tick event.
- Prescaler:
  - When run=1, div_cnt increments each cycle.
  - At div_cnt==TICK_DIV-1, div_cnt wraps to 0 and a tick event occurs. The tick output is registered and high the following cycle.
  - The first tick event occurs on the TICK_DIV-th run cycle after reset or restart.
  - When run=0: div_cnt, r, step and dir hold; no tick events. Partial counts are kept across pauses.
- restart=1: same state as reset (r=seed, dir=0, div_cnt=0, step=0) except mode_q is not changed. tick=0 that cycle. A tick event coinciding with restart is discarded.
- On a tick event, in this order:
  - If mode != mode_q: mode_q<=mode, r<=seed, dir<=0, step<=0. No pattern advance.
  - Else if RELOAD_STEPS!=0 and step==RELOAD_STEPS-1: r<=seed, dir<=0, step<=0.
  - Else: step<=step+1 (wraps mod 2^STEP_W when reload is disabled), and r advances per mode:
    - rotl: r <= {r[W-2:0], r[W-1]}.
    - rotr: r <= {r[0], r[W-1:1]}.
    - bounce, dir=0: shift toward MSB. If r[W-1]=1 instead, set dir=1 and move to bit W-2.
    - bounce, dir=1: shift toward LSB. If r[0]=1 instead, set dir=0 and move to bit 1.
    - fill: r <= {r[W-2:0],1}. If r is all ones, r<=seed instead.
- mode is sampled only at tick events. A mid-period mode change takes effect at the next tick, as a re-seed.
- r in rotl, rotr and bounce stays one-hot. In fill it is a thermometer code. A mode change always re-seeds, so no illegal code survives the switch.
- sw and POLARITY affect pat only, never state.

Test Plan:
(Bench config: WIDTH=8, TICK_DIV=4, RELOAD_STEPS=6, POLARITY=0 unless noted.)
1. rst 1 cycle, mode=00, run=1, sw=0.
   - pat=FE right after reset; tick high 4 cycles after rst release.
   - pat sequence FD,FB,F7,EF,DF, step 1..5.
   - 6th tick: pat=FE, step=0.
2. POLARITY=1, RELOAD_STEPS=0, mode held 10.
   - Before the first tick, pat=01.
   - Ticks then give 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02.
   - dir flips exactly at 80 and 01.
3. POLARITY=1, RELOAD_STEPS=0, mode=11, applied before the first tick.
   - First tick: seed 01, step 0.
   - Then 03,07,0F,1F,3F,7F,FF,01.
4. run=0 for 20 cycles after 2 of 4 prescaler counts.
   - No tick, pat and step unchanged.
   - After run=1, the next tick comes after exactly 2 more cycles.
5. restart asserted in the same cycle as a tick event at pat=F7.
   - pat=FE, step=0, no tick pulse.
   - Next tick 4 run-cycles later gives FD.
6. Switch mode 00→11 mid-period at pat=FB with sw=0F.
   - pat=FF until the tick (FB|0F).
   - At the tick: r=seed, pat=FF (FE|0F), step=0.
   - Subsequent tick gives FC|0F=FF.
   - With sw=00: FC, F8.

Source files
------------

// File: rtl/led_pattern_seq_if.sv
// Control and display bundle of the LED pattern sequencer.
// The master side (board logic or testbench) drives the controls and the
// switch overlay; the slave side (the sequencer) drives the display outputs.
interface led_pattern_seq_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
);
    logic              run;
    logic              restart;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  sw;
    logic [WIDTH-1:0]  pat;
    logic              tick;
    logic [STEP_W-1:0] step;

    modport master (
        output run, restart, mode, sw,
        input  pat, tick, step
    );

    modport slave (
        input  run, restart, mode, sw,
        output pat, tick, step
    );
endinterface

// File: rtl/led_pattern_seq.sv
// LED / segment pattern sequencer.
// A clock-enable prescaler (not a derived clock) advances a WIDTH-bit pattern
// register in one of four modes: rotate left, rotate right, bounce or fill.
// Every mode starts from the single-bit seed at position 0. Changing mode
// re-seeds at the next step, so no code from the old mode carries over.
// The display polarity and the switch overlay act on the output only and
// never feed back into the state.
// The interface instance must carry the same WIDTH and STEP_W as this module.
module led_pattern_seq #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 33554432,
    parameter int RELOAD_STEPS = 16,
    parameter int STEP_W       = 8,
    parameter int POLARITY     = 0
) (
    input  logic             mclk,
    input  logic             rst,
    led_pattern_seq_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    localparam int                DIV_W       = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] RELOAD_LAST = STEP_W'((RELOAD_STEPS == 0) ? 0 : RELOAD_STEPS - 1);
    localparam logic [WIDTH-1:0]  SEED        = WIDTH'(1);
    // Bounce turn-around targets: one in from either end.
    localparam logic [WIDTH-1:0]  BOUNCE_TOP  = SEED << (WIDTH - 2);
    localparam logic [WIDTH-1:0]  BOUNCE_BOT  = SEED << 1;
    localparam logic [WIDTH-1:0]  ALL_ONES    = '1;

    logic [WIDTH-1:0]  r_q;
    logic              dir_q;      // 0 = moving toward MSB
    logic [DIV_W-1:0]  div_q;
    logic [STEP_W-1:0] step_q;
    mode_e             mode_q;
    logic              tick_q;

    logic              tick_evt;
    logic              mode_chg;
    logic              reload_hit;
    logic [WIDTH-1:0]  r_adv;
    logic              dir_adv;

    assign tick_evt   = bus.run && (div_q == DIV_LAST);
    assign mode_chg   = (mode_e'(bus.mode) != mode_q);
    assign reload_hit = (RELOAD_STEPS != 0) && (step_q == RELOAD_LAST);

    // Next pattern and bounce direction for a plain advance in the current mode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        r_adv   = r_q;
        dir_adv = dir_q;
        case (mode_q)
            MODE_ROTL: r_adv = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROTR: r_adv = {r_q[0], r_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    if (r_q[WIDTH-1]) begin
                        dir_adv = 1'b1;
                        r_adv   = BOUNCE_TOP;
                    end else begin
                        r_adv = r_q << 1;
                    end
                end else begin
                    if (r_q[0]) begin
                        dir_adv = 1'b0;
                        r_adv   = BOUNCE_BOT;
                    end else begin
                        r_adv = r_q >> 1;
                    end
                end
            end
            MODE_FILL: r_adv = (r_q == ALL_ONES) ? SEED : {r_q[WIDTH-2:0], 1'b1};
            default: r_adv = r_q;
        endcase
    end

    // Prescaler, step strobe and pattern state; rst beats restart beats a tick event.
    always_ff @(posedge mclk) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_q    <= SEED;
            dir_q  <= 1'b0;
            div_q  <= '0;
            step_q <= '0;
            tick_q <= 1'b0;
            mode_q <= MODE_ROTL;
        end else if (bus.restart) begin
            // Same as reset except the applied mode is kept; a coinciding
            // tick event is dropped.
            r_q    <= SEED;
            dir_q  <= 1'b0;
            div_q  <= '0;
            step_q <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_evt;
            if (bus.run) begin
                div_q <= tick_evt ? '0 : div_q + DIV_W'(1);
            end
            if (tick_evt) begin
                if (mode_chg) begin
                    mode_q <= mode_e'(bus.mode);
                    r_q    <= SEED;
                    dir_q  <= 1'b0;
                    step_q <= '0;
                end else if (reload_hit) begin
                    r_q    <= SEED;
                    dir_q  <= 1'b0;
                    step_q <= '0;
                end else begin
                    r_q    <= r_adv;
                    dir_q  <= dir_adv;
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

    assign bus.pat  = ((POLARITY != 0) ? r_q : ~r_q) | bus.sw;
    assign bus.tick = tick_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: a vector table and directed sequences for the
// corner cases, then randomized stimulus against a reference model.
// Two instances with WIDTH=8 and TICK_DIV=4 are used:
//   dut_a: RELOAD_STEPS=6, POLARITY=0
//   dut_b: RELOAD_STEPS=0, POLARITY=1
`timescale 1ns/1ps
module tb_led_pattern_seq;
    localparam int W    = 8;
    localparam int TDIV = 4;

    logic mclk = 1'b0;
    logic rst;
    always #5 mclk = ~mclk;

    led_pattern_seq_if #(.WIDTH(W), .STEP_W(8)) bus_a ();
    led_pattern_seq_if #(.WIDTH(W), .STEP_W(8)) bus_b ();

    led_pattern_seq #(.WIDTH(W), .TICK_DIV(TDIV), .RELOAD_STEPS(6), .STEP_W(8), .POLARITY(0))
        dut_a (.mclk(mclk), .rst(rst), .bus(bus_a.slave));
    led_pattern_seq #(.WIDTH(W), .TICK_DIV(TDIV), .RELOAD_STEPS(0), .STEP_W(8), .POLARITY(1))
        dut_b (.mclk(mclk), .rst(rst), .bus(bus_b.slave));

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step_clk();
        @(posedge mclk);
        #1;
    endtask

    // Run one prescaler period: tick low for TDIV-1 cycles, high on the last,
    // then compare pattern and step of the selected instance.
    task automatic expect_tick(input bit is_b, input logic [7:0] exp_pat,
                               input logic [7:0] exp_step, input string tag);
        for (int i = 0; i < TDIV; i++) begin
            step_clk();
            check({tag, " tick"}, is_b ? bus_b.tick : bus_a.tick, (i == TDIV - 1) ? 1 : 0);
        end
        check({tag, " pat"},  is_b ? bus_b.pat  : bus_a.pat,  exp_pat);
        check({tag, " step"}, is_b ? bus_b.step : bus_a.step, exp_step);
    endtask

    // ---------------- reference model ----------------
    // The pattern is kept as a marker position (one-hot modes) or a fill
    // level (fill mode); the prescaler as a count of run cycles.
    typedef struct {
        int pos;
        int lvl;
        int dir;
        int div;
        int step;
        int mode_q;
        bit tick;
    } mdl_t;

    function automatic mdl_t mdl_reseed(mdl_t m);
        m.pos  = 0;
        m.lvl  = 1;
        m.dir  = 1;
        m.step = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit r, bit run, bit restart, int mode, int reload);
        bit ev;
        if (r || restart) begin
            m      = mdl_reseed(m);
            m.div  = 0;
            m.tick = 0;
            if (r) m.mode_q = 0;
            return m;
        end
        ev     = run && (m.div == TDIV - 1);
        m.tick = ev;
        if (run) m.div = (m.div + 1) % TDIV;
        if (ev) begin
            if (mode != m.mode_q) begin
                m.mode_q = mode;
                m = mdl_reseed(m);
            end else if (reload != 0 && m.step == reload - 1) begin
                m = mdl_reseed(m);
            end else begin
                m.step = (m.step + 1) % 256;
                case (mode)
                    0: m.pos = (m.pos + 1) % W;
                    1: m.pos = (m.pos + W - 1) % W;
                    2: begin
                        if (m.pos + m.dir < 0 || m.pos + m.dir > W - 1) m.dir = -m.dir;
                        m.pos = m.pos + m.dir;
                    end
                    default: m.lvl = (m.lvl == W) ? 1 : m.lvl + 1;
                endcase
            end
        end
        return m;
    endfunction

    function automatic logic [7:0] mdl_pat(mdl_t m, bit pol, logic [7:0] sw);
        int r;
        r = (m.mode_q == 3) ? ((1 << m.lvl) - 1) : (1 << m.pos);
        r = r & 8'hFF;
        return pol ? (8'(r) | sw) : (~8'(r) | sw);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit         run;
        bit         restart;
        logic [1:0] mode;
        logic [7:0] sw;
        logic [7:0] exp_pat;
        bit         exp_tick;
        logic [7:0] exp_step;
    } vec_t;

    vec_t       vecs [24];
    logic [7:0] rotl_seq [7];
    logic [7:0] bounce_seq [15];
    logic [7:0] fill_seq [8];
    mdl_t       ma;
    mdl_t       mb;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        rotl_seq   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE};
        bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        fill_seq   = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

        // Rotate-left run from reset: a tick every TDIV cycles, reload on the 6th.
        for (int i = 0; i < 24; i++) begin
            int n;
            n = (i + 1) / TDIV;
            vecs[i].run      = 1'b1;
            vecs[i].restart  = 1'b0;
            vecs[i].mode     = 2'b00;
            vecs[i].sw       = 8'h00;
            vecs[i].exp_pat  = rotl_seq[n];
            vecs[i].exp_tick = ((i + 1) % TDIV == 0);
            vecs[i].exp_step = (n < 6) ? 8'(n) : 8'h00;
        end

        bus_a.run = 1'b1; bus_a.restart = 1'b0; bus_a.mode = 2'b00; bus_a.sw = 8'h00;
        bus_b.run = 1'b0; bus_b.restart = 1'b0; bus_b.mode = 2'b00; bus_b.sw = 8'h00;
        rst = 1'b1;
        step_clk();
        check("reset pat_a",  bus_a.pat,  8'hFE);
        check("reset tick_a", bus_a.tick, 1'b0);
        check("reset step_a", bus_a.step, 8'h00);
        check("reset pat_b",  bus_b.pat,  8'h01);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            bus_a.run     = vecs[i].run;
            bus_a.restart = vecs[i].restart;
            bus_a.mode    = vecs[i].mode;
            bus_a.sw      = vecs[i].sw;
            step_clk();
            check($sformatf("vec%0d pat", i),  bus_a.pat,  vecs[i].exp_pat);
            check($sformatf("vec%0d tick", i), bus_a.tick, vecs[i].exp_tick);
            check($sformatf("vec%0d step", i), bus_a.step, vecs[i].exp_step);
        end

        // Restart coinciding with a tick event at F7.
        expect_tick(0, 8'hFD, 8'd1, "rs pre1");
        expect_tick(0, 8'hFB, 8'd2, "rs pre2");
        expect_tick(0, 8'hF7, 8'd3, "rs pre3");
        for (int i = 0; i < TDIV - 1; i++) step_clk();
        bus_a.restart = 1'b1;
        step_clk();
        check("restart pat",  bus_a.pat,  8'hFE);
        check("restart tick", bus_a.tick, 1'b0);
        check("restart step", bus_a.step, 8'h00);
        bus_a.restart = 1'b0;
        expect_tick(0, 8'hFD, 8'd1, "rs post");

        // Pause after 2 of 4 prescaler counts; partial count is kept.
        step_clk();
        step_clk();
        bus_a.run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            check("pause tick", bus_a.tick, 1'b0);
        end
        check("pause pat",  bus_a.pat,  8'hFD);
        check("pause step", bus_a.step, 8'd1);
        bus_a.run = 1'b1;
        step_clk();
        check("resume tick1", bus_a.tick, 1'b0);
        step_clk();
        check("resume tick2", bus_a.tick, 1'b1);
        check("resume pat",   bus_a.pat,  8'hFB);
        check("resume step",  bus_a.step, 8'd2);

        // Mid-period mode switch rotl -> fill with the switch overlay active.
        step_clk();
        bus_a.sw   = 8'h0F;
        bus_a.mode = 2'b11;
        #1;
        check("msw overlay pat", bus_a.pat, 8'hFF);
        step_clk();
        step_clk();
        check("msw no tick", bus_a.tick, 1'b0);
        step_clk();
        check("msw tick", bus_a.tick, 1'b1);
        check("msw pat",  bus_a.pat,  8'hFF);
        check("msw step", bus_a.step, 8'd0);
        expect_tick(0, 8'hFF, 8'd1, "msw fill1");
        bus_a.sw = 8'h00;
        #1;
        check("msw sw off pat", bus_a.pat, 8'hFC);
        expect_tick(0, 8'hF8, 8'd2, "msw fill2");

        // Bounce on the walking-one instance: first tick re-seeds (mode change).
        bus_a.run = 1'b0;
        bus_b.run = 1'b1;
        bus_b.mode = 2'b10;
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        check("bounce seed pat", bus_b.pat, 8'h01);
        expect_tick(1, 8'h01, 8'd0, "bounce t0");
        for (int i = 0; i < 15; i++)
            expect_tick(1, bounce_seq[i], 8'(i + 1), $sformatf("bounce t%0d", i + 1));

        // Fill on the walking-one instance, wrap from all ones back to the seed.
        bus_b.mode = 2'b11;
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        expect_tick(1, 8'h01, 8'd0, "fill t0");
        for (int i = 0; i < 8; i++)
            expect_tick(1, fill_seq[i], 8'(i + 1), $sformatf("fill t%0d", i + 1));

        // Randomized stimulus on both instances against the model.
        ma = '{default: 0};
        mb = '{default: 0};
        for (int i = 0; i < 4000; i++) begin
            rst           = (i == 0) || ($urandom_range(0, 1499) == 0);
            bus_a.run     = ($urandom_range(0, 9) < 8);
            bus_b.run     = ($urandom_range(0, 9) < 8);
            bus_a.restart = ($urandom_range(0, 199) == 0);
            bus_b.restart = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) bus_a.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) bus_b.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                bus_a.sw = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0)
                bus_b.sw = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            @(posedge mclk);
            ma = mdl_next(ma, rst, bus_a.run, bus_a.restart, int'(bus_a.mode), 6);
            mb = mdl_next(mb, rst, bus_b.run, bus_b.restart, int'(bus_b.mode), 0);
            #1;
            check($sformatf("rnd%0d pat_a", i),  bus_a.pat,  mdl_pat(ma, 1'b0, bus_a.sw));
            check($sformatf("rnd%0d tick_a", i), bus_a.tick, ma.tick);
            check($sformatf("rnd%0d step_a", i), bus_a.step, 8'(ma.step));
            check($sformatf("rnd%0d pat_b", i),  bus_b.pat,  mdl_pat(mb, 1'b1, bus_b.sw));
            check($sformatf("rnd%0d tick_b", i), bus_b.tick, mb.tick);
            check($sformatf("rnd%0d step_b", i), bus_b.step, 8'(mb.step));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
